// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-access sequencer: memory commands and FSM states.
package mem_access_pkg;

   // One-hot memory command, also decoded by the CPU top.
   localparam logic [2:0] MNONE  = 3'b001;
   localparam logic [2:0] MREAD  = 3'b010;
   localparam logic [2:0] MWRITE = 3'b100;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_STORE = 3'd3;
   localparam logic [2:0] ST_ERROR = 3'd4;

   function automatic logic [2:0] cmd_of(input logic [2:0] st);
      logic [2:0] c;
      c = MNONE;
      case (st)
         ST_FETCH, ST_LOAD: c = MREAD;
         ST_STORE:          c = MWRITE;
         default:           c = MNONE;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/status and memory-side bus of the memory-access sequencer.
interface mem_access_unit_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
);
   logic              fetch_req;
   logic              ls_req;
   logic              ls_write;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_target;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] ls_rdata;
   logic              fetch_done;
   logic              ls_done;
   logic              busy;
   logic              err;
   logic [ADDR_W-1:0] mem_addr;
   logic [2:0]        mem_cmd;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // master: the sequencer itself; slave: control FSM plus memory around it.
   modport master (
      input  fetch_req, ls_req, ls_write, ls_addr, ls_wdata, pc_load, pc_target,
             mem_rdata, mem_ready,
      output pc, ir, ls_rdata, fetch_done, ls_done, busy, err,
             mem_addr, mem_cmd, mem_wdata
   );

   modport slave (
      output fetch_req, ls_req, ls_write, ls_addr, ls_wdata, pc_load, pc_target,
             mem_rdata, mem_ready,
      input  pc, ir, ls_rdata, fetch_done, ls_done, busy, err,
             mem_addr, mem_cmd, mem_wdata
   );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-state counter; expired flags the wait cycle that makes the count reach TIMEOUT.
module mem_wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

   logic [CW-1:0] r_cnt;

   // Saturates at LIMIT; with TIMEOUT=0 it never moves and never expires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     r_cnt <= '0;
      else if (i_clr)                 r_cnt <= '0;
      else if (i_en && r_cnt != LIMIT) r_cnt <= r_cnt + 1'b1;
   end

   assign o_expired = (TIMEOUT > 0) && i_en && (r_cnt == LIMIT - 1'b1);

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access sequencer: owns PC/IR/data address, runs fetch, load and store with wait states.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_W   = 9,
   parameter int DATA_W   = 16,
   parameter int TIMEOUT  = 15,
   parameter int RESET_PC = 0
) (
   input  logic             clk,
   input  logic             reset,
   mem_access_unit_if.master bus
);
   logic [2:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] r_rdata;
   logic              r_fdone;
   logic              r_ldone;
   logic              r_err;

   logic w_active;
   logic w_accept;
   logic w_expired;

   assign w_active = (r_state == ST_FETCH) || (r_state == ST_LOAD) || (r_state == ST_STORE);
   assign w_accept = (r_state == ST_IDLE) && (bus.ls_req || bus.fetch_req);

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk       (clk),
      .rst_n     (reset),
      .i_clr     (w_accept),
      .i_en      (w_active && !bus.mem_ready),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_pc    <= ADDR_W'(RESET_PC);
         r_addr  <= '0;
         r_wdata <= '0;
         r_ir    <= '0;
         r_rdata <= '0;
         r_fdone <= 1'b0;
         r_ldone <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_fdone <= 1'b0;
         r_ldone <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A branch in the same cycle as fetch_req redirects that fetch.
               if (bus.pc_load) r_pc <= bus.pc_target;
               if (bus.ls_req) begin
                  r_addr  <= bus.ls_addr;
                  r_wdata <= bus.ls_wdata;
                  r_state <= bus.ls_write ? ST_STORE : ST_LOAD;
               end else if (bus.fetch_req) begin
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (bus.mem_ready) begin
                  r_ir    <= bus.mem_rdata;
                  r_pc    <= r_pc + 1'b1;
                  r_fdone <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= ST_ERROR;
               end
            end
            ST_LOAD: begin
               if (bus.mem_ready) begin
                  r_rdata <= bus.mem_rdata;
                  r_ldone <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= ST_ERROR;
               end
            end
            ST_STORE: begin
               if (bus.mem_ready) begin
                  r_ldone <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= ST_ERROR;
               end
            end
            default: r_state <= r_state;  // ERROR is left only through reset
         endcase
      end
   end

   assign bus.mem_cmd    = cmd_of(r_state);
   assign bus.mem_addr   = ((r_state == ST_LOAD) || (r_state == ST_STORE)) ? r_addr : r_pc;
   assign bus.mem_wdata  = r_wdata;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.pc         = r_pc;
   assign bus.ir         = r_ir;
   assign bus.ls_rdata   = r_rdata;
   assign bus.fetch_done = r_fdone;
   assign bus.ls_done    = r_ldone;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized traffic against a transaction model.
module tb_mem_access_unit;
   import mem_access_pkg::*;

   localparam int AW  = 9;
   localparam int DW  = 16;
   localparam int TO  = 15;
   localparam int RPC = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level model: memory contents plus architectural registers.
   logic [DW-1:0] mem_m [2**AW];
   logic [AW-1:0] m_pc;
   logic [DW-1:0] m_ir;
   logic [DW-1:0] m_rd;

   task automatic idle_inputs();
      bus.fetch_req = 1'b0; bus.ls_req = 1'b0; bus.ls_write = 1'b0;
      bus.ls_addr = '0; bus.ls_wdata = '0; bus.pc_load = 1'b0; bus.pc_target = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
   endtask

   function automatic void model_apply(input int kind, input logic [AW-1:0] a,
                                       input logic [DW-1:0] wd, input logic pl,
                                       input logic [AW-1:0] pt);
      if (pl) m_pc = pt;
      case (kind)
         0: begin m_ir = mem_m[m_pc]; m_pc = m_pc + 1'b1; end
         1: m_rd = mem_m[a];
         default: mem_m[a] = wd;
      endcase
   endfunction

   // Plays the CPU and memory for one transaction (kind 0 fetch, 1 load, 2 store) and
   // reports what it observed; done_cyc counts cycles from the request cycle.
   task automatic run_txn(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int waits, input logic also_fetch, input logic pl,
                          input logic [AW-1:0] pt, input logic noise,
                          output int bad_cmd, output int bad_addr, output int bad_wd,
                          output int done_cyc, output int done_len, output logic [1:0] which);
      logic [AW-1:0] ea;
      logic [2:0]    ec;
      logic [DW-1:0] rd;
      ea = (kind == 0) ? (pl ? pt : m_pc) : a;
      ec = (kind == 2) ? MWRITE : MREAD;
      rd = mem_m[ea];
      bad_cmd = 0; bad_addr = 0; bad_wd = 0; done_cyc = -1; done_len = 0; which = 2'b00;
      @(posedge clk); #1;
      bus.fetch_req = (kind == 0) || also_fetch;
      bus.ls_req    = (kind != 0);
      bus.ls_write  = (kind == 2);
      bus.ls_addr   = a;
      bus.ls_wdata  = wd;
      bus.pc_load   = pl;
      bus.pc_target = pt;
      bus.mem_ready = (waits == 0);
      bus.mem_rdata = (waits == 0) ? rd : DW'($urandom);
      for (int c = 0; c < waits + 4; c++) begin
         @(posedge clk); #1;
         if (noise && c <= waits) begin
            bus.fetch_req = 1'($urandom); bus.ls_req = 1'($urandom); bus.ls_write = 1'($urandom);
            bus.ls_addr = AW'($urandom); bus.ls_wdata = DW'($urandom);
            bus.pc_load = 1'($urandom); bus.pc_target = AW'($urandom);
         end else begin
            bus.fetch_req = 1'b0; bus.ls_req = 1'b0; bus.ls_write = 1'b0; bus.pc_load = 1'b0;
         end
         bus.mem_ready = (c == waits);
         bus.mem_rdata = (c == waits) ? rd : DW'($urandom);
         @(negedge clk);
         if (c <= waits) begin
            if (bus.mem_cmd !== ec || bus.busy !== 1'b1) bad_cmd++;
            if (bus.mem_addr !== ea) bad_addr++;
            if (kind == 2 && bus.mem_wdata !== wd) bad_wd++;
         end
         if (bus.fetch_done || bus.ls_done) begin
            if (done_cyc < 0) done_cyc = c + 1;
            done_len++;
            which = which | {bus.fetch_done, bus.ls_done};
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset();
      int seen;
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      m_pc = AW'(RPC); m_ir = '0; m_rd = '0;
      @(negedge clk);
      checks++; if (bus.pc !== AW'(RPC)) begin errors++; $display("FAIL reset_pc got %0h exp %0h", bus.pc, RPC); end
      checks++; if (bus.mem_cmd !== MNONE || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
         errors++; $display("FAIL reset_ctl got cmd=%b busy=%b err=%b exp cmd=001 busy=0 err=0", bus.mem_cmd, bus.busy, bus.err); end
      checks++; if (bus.mem_addr !== AW'(RPC) || bus.mem_wdata !== '0) begin
         errors++; $display("FAIL reset_bus got addr=%0h wdata=%0h exp addr=%0h wdata=0", bus.mem_addr, bus.mem_wdata, RPC); end
      checks++; if (bus.ir !== '0 || bus.ls_rdata !== '0 || bus.fetch_done !== 1'b0 || bus.ls_done !== 1'b0) begin
         errors++; $display("FAIL reset_regs got ir=%0h rd=%0h fd=%b ld=%b exp 0", bus.ir, bus.ls_rdata, bus.fetch_done, bus.ls_done); end
      // Abort a fetch stuck in wait states.
      @(posedge clk); #1 bus.fetch_req = 1'b1; bus.mem_ready = 1'b0;
      @(posedge clk); #1 bus.fetch_req = 1'b0;
      @(posedge clk); @(posedge clk); #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.mem_cmd !== MNONE || bus.pc !== AW'(RPC)) begin
         errors++; $display("FAIL reset_abort got busy=%b cmd=%b pc=%0h exp busy=0 cmd=001 pc=%0h", bus.busy, bus.mem_cmd, bus.pc, RPC); end
      @(posedge clk); #1 rst_n = 1'b1; bus.mem_ready = 1'b1;
      seen = 0;
      repeat (3) begin @(negedge clk); if (bus.fetch_done || bus.ls_done || bus.busy) seen++; end
      checks++; if (seen !== 0) begin errors++; $display("FAIL reset_no_done got %0d exp 0", seen); end
      idle_inputs();
   endtask

   task automatic test_fetch_zero_wait();
      int bc, ba, bw, dc, dl; logic [1:0] wh;
      mem_m[m_pc] = 16'hA5C3;
      run_txn(0, '0, '0, 0, 1'b0, 1'b0, '0, 1'b0, bc, ba, bw, dc, dl, wh);
      model_apply(0, '0, '0, 1'b0, '0);
      checks++; if (bc !== 0 || ba !== 0) begin errors++; $display("FAIL fetch0_bus got badcmd=%0d badaddr=%0d exp 0", bc, ba); end
      checks++; if (dc !== 2 || dl !== 1 || wh !== 2'b10) begin
         errors++; $display("FAIL fetch0_done got cyc=%0d len=%0d which=%b exp 2 1 10", dc, dl, wh); end
      checks++; if (bus.ir !== 16'hA5C3 || bus.pc !== 9'd6) begin
         errors++; $display("FAIL fetch0_regs got ir=%0h pc=%0h exp a5c3 6", bus.ir, bus.pc); end
   endtask

   task automatic test_load_wait();
      int bc, ba, bw, dc, dl; logic [1:0] wh;
      mem_m[9'h1F0] = 16'h0042;
      run_txn(1, 9'h1F0, '0, 3, 1'b0, 1'b0, '0, 1'b1, bc, ba, bw, dc, dl, wh);
      model_apply(1, 9'h1F0, '0, 1'b0, '0);
      checks++; if (bc !== 0 || ba !== 0) begin errors++; $display("FAIL load3_bus got badcmd=%0d badaddr=%0d exp 0", bc, ba); end
      checks++; if (dc !== 5 || dl !== 1 || wh !== 2'b01) begin
         errors++; $display("FAIL load3_done got cyc=%0d len=%0d which=%b exp 5 1 01", dc, dl, wh); end
      checks++; if (bus.ls_rdata !== 16'h0042 || bus.pc !== m_pc) begin
         errors++; $display("FAIL load3_regs got rd=%0h pc=%0h exp 0042 %0h", bus.ls_rdata, bus.pc, m_pc); end
   endtask

   task automatic test_store_priority();
      int bc, ba, bw, dc, dl; logic [1:0] wh;
      run_txn(2, 9'd3, 16'hBEEF, 1, 1'b1, 1'b0, '0, 1'b0, bc, ba, bw, dc, dl, wh);
      model_apply(2, 9'd3, 16'hBEEF, 1'b0, '0);
      checks++; if (bc !== 0 || ba !== 0 || bw !== 0) begin
         errors++; $display("FAIL store_bus got badcmd=%0d badaddr=%0d badwd=%0d exp 0", bc, ba, bw); end
      checks++; if (dc !== 3 || dl !== 1 || wh !== 2'b01) begin
         errors++; $display("FAIL store_done got cyc=%0d len=%0d which=%b exp 3 1 01", dc, dl, wh); end
      run_txn(0, '0, '0, 0, 1'b0, 1'b0, '0, 1'b0, bc, ba, bw, dc, dl, wh);
      model_apply(0, '0, '0, 1'b0, '0);
      checks++; if (bc !== 0 || ba !== 0 || dc !== 2 || wh !== 2'b10) begin
         errors++; $display("FAIL store_refetch got badcmd=%0d badaddr=%0d cyc=%0d which=%b exp 0 0 2 10", bc, ba, dc, wh); end
      checks++; if (bus.ir !== m_ir || bus.pc !== m_pc) begin
         errors++; $display("FAIL store_refetch_regs got ir=%0h pc=%0h exp %0h %0h", bus.ir, bus.pc, m_ir, m_pc); end
   endtask

   task automatic test_branch_wrap();
      int bc, ba, bw, dc, dl; logic [1:0] wh;
      run_txn(0, '0, '0, 2, 1'b0, 1'b1, 9'h1FF, 1'b0, bc, ba, bw, dc, dl, wh);
      model_apply(0, '0, '0, 1'b1, 9'h1FF);
      checks++; if (bc !== 0 || ba !== 0) begin errors++; $display("FAIL branch_bus got badcmd=%0d badaddr=%0d exp 0", bc, ba); end
      checks++; if (dc !== 4 || dl !== 1 || wh !== 2'b10) begin
         errors++; $display("FAIL branch_done got cyc=%0d len=%0d which=%b exp 4 1 10", dc, dl, wh); end
      checks++; if (bus.pc !== 9'd0 || bus.ir !== m_ir) begin
         errors++; $display("FAIL branch_wrap got pc=%0h ir=%0h exp 0 %0h", bus.pc, bus.ir, m_ir); end
   endtask

   task automatic test_random();
      int bc, ba, bw, dc, dl, kind, w; logic [1:0] wh, exp_wh;
      logic [AW-1:0] a, pt; logic [DW-1:0] wd; logic pl, af;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(2, 0); w = $urandom_range(5, 0);
         a = AW'($urandom); wd = DW'($urandom); pt = AW'($urandom);
         pl = ($urandom_range(3, 0) == 0); af = 1'($urandom);
         run_txn(kind, a, wd, w, af, pl, pt, 1'b1, bc, ba, bw, dc, dl, wh);
         model_apply(kind, a, wd, pl, pt);
         exp_wh = (kind == 0) ? 2'b10 : 2'b01;
         checks++;
         if (bc !== 0 || ba !== 0 || bw !== 0 || dc !== w + 2 || dl !== 1 || wh !== exp_wh ||
             bus.pc !== m_pc || bus.ir !== m_ir || bus.ls_rdata !== m_rd) begin
            errors++;
            $display("FAIL rand_txn%0d kind=%0d waits=%0d got bad=%0d/%0d/%0d cyc=%0d len=%0d which=%b pc=%0h ir=%0h rd=%0h exp cyc=%0d which=%b pc=%0h ir=%0h rd=%0h",
                     n, kind, w, bc, ba, bw, dc, dl, wh, bus.pc, bus.ir, bus.ls_rdata, w + 2, exp_wh, m_pc, m_ir, m_rd);
         end
      end
   endtask

   task automatic test_timeout();
      int early, ign;
      early = 0; ign = 0;
      @(posedge clk); #1 bus.fetch_req = 1'b1; bus.mem_ready = 1'b0;
      @(posedge clk); #1 bus.fetch_req = 1'b0;
      for (int c = 0; c < TO; c++) begin
         @(negedge clk);
         if (bus.err !== 1'b0 || bus.mem_cmd !== MREAD) early++;
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++; if (early !== 0) begin errors++; $display("FAIL timeout_early got %0d exp 0", early); end
      checks++; if (bus.err !== 1'b1 || bus.mem_cmd !== MNONE || bus.busy !== 1'b1) begin
         errors++; $display("FAIL timeout_err got err=%b cmd=%b busy=%b exp 1 001 1", bus.err, bus.mem_cmd, bus.busy); end
      repeat (6) begin
         @(posedge clk); #1;
         bus.fetch_req = 1'($urandom); bus.ls_req = 1'($urandom); bus.pc_load = 1'b1;
         bus.pc_target = AW'($urandom); bus.mem_ready = 1'b1;
         @(negedge clk);
         if (bus.err !== 1'b1 || bus.mem_cmd !== MNONE || bus.fetch_done || bus.ls_done || bus.pc !== m_pc) ign++;
      end
      checks++; if (ign !== 0) begin errors++; $display("FAIL timeout_ignore got %0d exp 0", ign); end
      idle_inputs();
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.pc !== AW'(RPC)) begin
         errors++; $display("FAIL timeout_reset got err=%b busy=%b pc=%0h exp 0 0 %0h", bus.err, bus.busy, bus.pc, RPC); end
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) mem_m[i] = DW'($urandom);
      test_reset();
      test_fetch_zero_wait();
      test_load_wait();
      test_store_priority();
      test_branch_wrap();
      test_random();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
